// File: rtl/nios_pio_in_cap_if.sv
// nios_pio_in_cap_if: Avalon-MM slave bus plus interrupt line for the PIO input-capture block.
interface nios_pio_in_cap_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/nios_pio_in_cap.sv
// nios_pio_in_cap: Avalon-MM parallel input port with per-bit edge capture, irq mask and level interrupt.
// Define NIOS_PIO_IN_SYNC_EN to insert one synchroniser stage ahead of data_reg.
module nios_pio_in_cap #(
    parameter int WIDTH     = 16,
    parameter int EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    nios_pio_in_cap_if.slave bus
);
    logic [WIDTH-1:0] data_q, data_d, prev_q, prev_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d, edgecap_q, edgecap_d;
    logic [WIDTH-1:0] edge_term, clr_mask, wdata;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr;
    logic             unused_wdata;

    assign unused_wdata = ^bus.writedata;

`ifdef NIOS_PIO_IN_SYNC_EN
    logic [WIDTH-1:0] sync_q;

    // First synchroniser stage; data_q acts as the second flop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= in_port;
    end

    assign data_d = sync_q;
`else
    assign data_d = in_port;
`endif

    // Next-state for sampling pipeline, edge capture, mask and read mux
    always_comb begin
        wdata      = bus.writedata[WIDTH-1:0];
        wr         = bus.chipselect && !bus.write_n;
        prev_d     = data_q;
        edge_term  = EDGE_TYPE == 0 ? (data_q & ~prev_q) :
                     EDGE_TYPE == 1 ? (~data_q & prev_q) : (data_q ^ prev_q);
        clr_mask   = (wr && bus.address == 2'd3) ? wdata : '0;
        edgecap_d  = (edgecap_q & ~clr_mask) | edge_term;
        irqmask_d  = (wr && bus.address == 2'd2) ? wdata : irqmask_q;
        readdata_d = bus.address == 2'd0 ? 32'(data_q)    :
                     bus.address == 2'd2 ? 32'(irqmask_q) :
                     bus.address == 2'd3 ? 32'(edgecap_q) : 32'd0;
    end

    // State registers, all cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= '0;
            prev_q     <= '0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
        end else begin
            data_q     <= data_d;
            prev_q     <= prev_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = |(edgecap_q & irqmask_q);
endmodule

// File: tb/tb_nios_pio_in_cap.sv
// tb_nios_pio_in_cap: directed and random checks of three configurations against a behavioural model.
module tb_nios_pio_in_cap;
`ifdef NIOS_PIO_IN_SYNC_EN
    localparam int D = 1;
`else
    localparam int D = 0;
`endif
    localparam int LAT = 2 + D;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  addr = '0;
    logic        cs = 1'b0;
    logic        wn = 1'b1;
    logic [31:0] wd = '0;
    logic [15:0] pin16 = '0;
    logic [7:0]  pin8 = '0;
    logic [4:0]  pin5 = '0;

    int nchk = 0;
    int errs = 0;

    logic [31:0] hist [3][4];
    logic [31:0] cap [3];
    logic [31:0] msk [3];
    logic [31:0] rdm [3];
    logic [31:0] wm [3] = '{32'hFFFF, 32'hFF, 32'h1F};
    int          et [3] = '{0, 2, 1};

    nios_pio_in_cap_if bus16 ();
    nios_pio_in_cap_if bus8 ();
    nios_pio_in_cap_if bus5 ();

    assign bus16.address = addr; assign bus16.chipselect = cs; assign bus16.write_n = wn; assign bus16.writedata = wd;
    assign bus8.address  = addr; assign bus8.chipselect  = cs; assign bus8.write_n  = wn; assign bus8.writedata  = wd;
    assign bus5.address  = addr; assign bus5.chipselect  = cs; assign bus5.write_n  = wn; assign bus5.writedata  = wd;

    nios_pio_in_cap #(.WIDTH(16), .EDGE_TYPE(0)) u16 (.clk(clk), .reset_n(reset_n), .in_port(pin16), .bus(bus16));
    nios_pio_in_cap #(.WIDTH(8),  .EDGE_TYPE(2)) u8  (.clk(clk), .reset_n(reset_n), .in_port(pin8),  .bus(bus8));
    nios_pio_in_cap #(.WIDTH(5),  .EDGE_TYPE(1)) u5  (.clk(clk), .reset_n(reset_n), .in_port(pin5),  .bus(bus5));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pin_of(input int k);
        return k == 0 ? 32'(pin16) : k == 1 ? 32'(pin8) : 32'(pin5);
    endfunction

    function automatic logic [31:0] rd_of(input int k);
        return k == 0 ? bus16.readdata : k == 1 ? bus8.readdata : bus5.readdata;
    endfunction

    function automatic logic irq_of(input int k);
        return k == 0 ? bus16.irq : k == 1 ? bus8.irq : bus5.irq;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) hist[k][j] = '0;
            cap[k] = '0;
            msk[k] = '0;
            rdm[k] = '0;
        end
    endtask

    // hist[k][0] is the pin value seen at the latest edge; data_reg lags it by D edges
    task automatic model_update();
        logic [31:0] d, p, e, nrd;
        logic        w;
        w = cs && !wn;
        for (int k = 0; k < 3; k++) begin
            d = hist[k][D];
            p = hist[k][D+1];
            e = '0;
            for (int i = 0; i < 32; i++)
                if (wm[k][i] && d[i] != p[i] && (et[k] == 2 || ((et[k] == 0) == d[i]))) e[i] = 1'b1;
            nrd = addr == 0 ? d : addr == 2 ? msk[k] : addr == 3 ? cap[k] : 32'd0;
            cap[k] = ((w && addr == 3) ? (cap[k] & ~wd) : cap[k]) | e;
            if (w && addr == 2) msk[k] = wd & wm[k];
            rdm[k] = nrd;
            for (int j = 3; j > 0; j--) hist[k][j] = hist[k][j-1];
            hist[k][0] = pin_of(k);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rd%0d", k), rd_of(k), rdm[k]);
            check($sformatf("irq%0d", k), 32'(irq_of(k)), 32'(|(cap[k] & msk[k])));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] v);
        cs = 1'b1; wn = 1'b0; addr = a; wd = v;
        cycle();
        cs = 1'b0; wn = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a);
        addr = a;
        cycle();
    endtask

    initial begin
        pin16 = 16'hFFFF;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_rd", bus16.readdata, 32'd0);
        check("reset_irq", 32'(bus16.irq), 32'd0);
        reset_n = 1'b1;
        idle(LAT - 1);
        check("lat_early", bus16.readdata, 32'd0);
        cycle();
        check("lat_ffff", bus16.readdata, 32'h0000FFFF);

        wr(3, 32'hFFFF);
        pin16 = 16'h0000;
        idle(4);
        rd(3);
        check("cap_cleared", bus16.readdata, 32'd0);
        wr(2, 32'h0008);
        pin16 = 16'h0008;
        idle(4);
        check("irq_rise", 32'(bus16.irq), 32'd1);
        rd(3);
        check("cap_bit3", bus16.readdata, 32'h0008);
        wr(3, 32'h0008);
        check("irq_clr", 32'(bus16.irq), 32'd0);
        rd(3);
        check("cap_w1c", bus16.readdata, 32'd0);

        wr(2, 32'h0);
        pin16 = 16'h0009;
        idle(4);
        rd(3);
        check("masked_cap", bus16.readdata, 32'h0001);
        check("masked_irq", 32'(bus16.irq), 32'd0);
        wr(2, 32'h1);
        check("unmask_irq", 32'(bus16.irq), 32'd1);

        wr(3, 32'hFFFF);
        wr(2, 32'h4);
        pin16 = 16'h0000;
        idle(4);
        pin16 = 16'h0004;
        idle(1 + D);
        wr(3, 32'h0004);
        rd(3);
        check("collision", bus16.readdata, 32'h0004);

        pin8 = 8'hA5;
        idle(4);
        pin8 = 8'h00;
        idle(4);
        rd(3);
        check("any_edge_cap", bus8.readdata, 32'h000000A5);
        check("hi_zero", bus8.readdata >> 8, 32'd0);
        wr(2, 32'hFFFFFF00);
        rd(2);
        check("mask_hi_ignored", bus8.readdata, 32'd0);

        for (int n = 0; n < 500; n++) begin
            pin16 = 16'($urandom);
            pin8  = 8'($urandom);
            pin5  = 5'($urandom);
            addr  = 2'($urandom);
            cs    = $urandom_range(0, 3) == 0;
            wn    = $urandom_range(0, 1) == 0;
            wd    = $urandom;
            cycle();
        end
        cs = 1'b0; wn = 1'b1;

        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            check("midrst_rd", rd_of(k), 32'd0);
            check("midrst_irq", 32'(irq_of(k)), 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        rd(2);
        rd(3);

        for (int n = 0; n < 300; n++) begin
            pin16 = 16'($urandom);
            pin8  = 8'($urandom);
            pin5  = 5'($urandom);
            addr  = 2'($urandom);
            cs    = $urandom_range(0, 2) == 0;
            wn    = $urandom_range(0, 1) == 0;
            wd    = $urandom_range(0, 1) == 0 ? 32'hFFFFFFFF : $urandom;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchk, errs);
        $finish;
    end
endmodule
